// File: rtl/add_8.sv
// add_8: 8-bit ripple-carry adder built from gate-level full-adder cells.
// Inputs are added in one combinational pass and the result is registered,
// giving a 1-cycle latency. Optional signed-overflow output and flop are
// enabled by defining ADD8_OVERFLOW_EN.

// Single bit cell: AND/OR/XOR only, no behavioural arithmetic.
module add_8_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module add_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       c_in,
`ifdef ADD8_OVERFLOW_EN
    output logic       overflow,
`endif
    output logic [7:0] sum,
    output logic       c_out
);
    // c[i] is the carry into bit i; c[8] is the carry out of bit 7.
    logic [8:0] c;
    logic [7:0] s;

    assign c[0] = c_in;

    // Carry chain: c_in ripples through all eight cells to the c_out flop.
    for (genvar i = 0; i < 8; i++) begin : g_bit
        add_8_fa u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    logic [7:0] sum_d,   sum_q;
    logic       c_out_d, c_out_q;

    // Next-state values for the result register.
    always_comb begin
        sum_d   = s;
        c_out_d = c[8];
    end

    // Result register; reset only takes effect at a clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= 8'h00;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

`ifdef ADD8_OVERFLOW_EN
    logic overflow_d, overflow_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        overflow_d = c[8] ^ c[7];
    end

    // Overflow flag register, reset alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_add_8.sv
// Self-checking bench for add_8: directed vector table, hand-written reset
// and back-to-back sequences, and randomized/sweep stimulus against an
// arithmetic reference model. Overflow checks compile in with ADD8_OVERFLOW_EN.
module tb_add_8;
    logic       clk;
    logic       rst_n;
    logic [7:0] A, B;
    logic       c_in;
    logic [7:0] sum;
    logic       c_out;
`ifdef ADD8_OVERFLOW_EN
    logic       overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    add_8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .c_in     (c_in),
`ifdef ADD8_OVERFLOW_EN
        .overflow (overflow),
`endif
        .sum      (sum),
        .c_out    (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[7];

    // Reference: plain integer addition; overflow from operand/result signs.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
        int unsigned t;
        logic [7:0] s;
        logic       ov;
        t  = a + b + ci;
        s  = t[7:0];
        ov = (a[7] == b[7]) && (s[7] != a[7]);
        return {ov, (t > 255), s};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] es, input logic ec,
                             input logic eo);
        check({name, ".sum"}, sum, es);
        check({name, ".c_out"}, {7'd0, c_out}, {7'd0, ec});
`ifdef ADD8_OVERFLOW_EN
        check({name, ".ovf"}, {7'd0, overflow}, {7'd0, eo});
`else
        if (eo === 1'bx) n_checks = n_checks + 0;
`endif
    endtask

    // Drive inputs at the falling edge, then sample 1 after the rising edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic rn);
        @(negedge clk);
        A = a; B = b; c_in = ci; rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] ra, rb;
        logic       rc;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        A = 8'hFF; B = 8'hFF; c_in = 1'b1; rst_n = 1'b0;

        // Reset held for two edges with the maximum operands applied.
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        check_out("reset1", 8'h00, 1'b0, 1'b0);
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        check_out("reset2", 8'h00, 1'b0, 1'b0);
        step(8'hFF, 8'hFF, 1'b1, 1'b1);
        check_out("release", 8'hFF, 1'b1, 1'b0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1);
            check_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout,
                      vecs[i].exp_ovf);
        end

        // Reset has no asynchronous path: low between edges leaves outputs alone.
        step(8'h12, 8'h34, 1'b0, 1'b1);
        check_out("pre_async", 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_out("async_none", 8'h46, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("sync_rst", 8'h00, 1'b0, 1'b0);
        step(8'h80, 8'hFF, 1'b0, 1'b1);
        check_out("post_rst", 8'h7F, 1'b1, 1'b1);

        // Sweep A fully against boundary B values, both carry-ins, every cycle.
        for (int bi = 0; bi < 5; bi++) begin
            case (bi)
                0: rb = 8'h00;
                1: rb = 8'h01;
                2: rb = 8'h7F;
                3: rb = 8'h80;
                default: rb = 8'hFF;
            endcase
            for (int a = 0; a < 256; a++) begin
                for (int c = 0; c < 2; c++) begin
                    ra = 8'(a); rc = 1'(c);
                    m = model(ra, rb, rc);
                    step(ra, rb, rc, 1'b1);
                    check_out("sweep", m[7:0], m[8], m[9]);
                end
            end
        end

        // Randomized back-to-back stream with a one-cycle reset pulse mid-stream.
        for (int i = 0; i < 20000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            if (i == 7000) begin
                step(ra, rb, rc, 1'b0);
                check_out("rand_rst", 8'h00, 1'b0, 1'b0);
            end else begin
                m = model(ra, rb, rc);
                step(ra, rb, rc, 1'b1);
                check_out("rand", m[7:0], m[8], m[9]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
